// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e   : controller states (IDLE, RUN, DONE)
//   cnt_width : digit-counter width, clog2(n) but never less than 1 bit
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder, one slice of the serial datapath.
// Ports:
//   a, b   : DIGIT-bit addends
//   cin    : carry into bit 0
//   sum    : DIGIT-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow on the last digit)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Digit-serial adder/subtractor: computes A + B (sel=0) or A - B (sel=1)
// DIGIT bits per clock, LSB first, reusing one DIGIT-bit adder.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start, sel  : request pulse and operation select, sampled with A/B
//   A, B        : WIDTH-bit operands
//   busy        : high while digits are being processed
//   done        : one-cycle pulse when S/cout/ovf/zero carry a new result
//   S           : result modulo 2^WIDTH
//   cout        : carry out of MSB (for subtraction, 1 = no borrow)
//   ovf         : two's-complement overflow
//   zero        : S == 0
//   dbg_state_o : current controller state, for observation only
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// controller is in IDLE or DONE (busy=0). While busy=1, start is ignored and
// nothing is queued. Exactly N edges after acceptance, done is high for one
// cycle and the result outputs change; they hold until the next completion.
module serial_adder_subtractor
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output state_e           dbg_state_o
);

  localparam int             N    = WIDTH / DIGIT;
  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $fatal(1, "serial_adder_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, r_sh_q, r_sh_d;
  logic               c_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0]   s_q;

  logic [DIGIT-1:0]   sum_dig;
  logic               dig_cout, dig_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh_q[DIGIT-1:0]),
    .b     (b_sh_q[DIGIT-1:0]),
    .cin   (c_q),
    .sum   (sum_dig),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // The new digit enters at the top; after N shifts the first digit has
  // reached the LSB end. With N=1 the whole register is replaced.
  always_comb begin
    r_sh_d = r_sh_q >> DIGIT;
    r_sh_d[WIDTH-1 -: DIGIT] = sum_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as c.
            a_sh_q  <= A;
            b_sh_q  <= sel ? ~B : B;
            c_q     <= sel;
            cnt_q   <= '0;
            r_sh_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> DIGIT;
          b_sh_q <= b_sh_q >> DIGIT;
          r_sh_q <= r_sh_d;
          c_q    <= dig_cout;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q     <= r_sh_d;
            cout_q  <= dig_cout;
            // Overflow when carry into the sign bit differs from carry out.
            ovf_q   <= dig_cmsb ^ dig_cout;
            zero_q  <= (r_sh_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign S           = s_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor. Five instances share clock/reset and the
// operand bus; each has its own start. Index: 0=(4,1) 1=(8,4) 2=(8,1)
// 3=(8,2) 4=(8,8). Results are packed {S[7:0], cout, ovf, zero}.
module tb_serial_adder_subtractor;
  import serial_addsub_pkg::*;

  localparam int LAT [5] = '{4, 2, 8, 4, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [4:0] start_v = '0;
  logic       sel_v = 1'b0;
  logic [7:0] a_v = '0, b_v = '0;
  logic [4:0] busy_w, done_w, cout_w, ovf_w, zero_w;
  logic [7:0] s_w [5];
  logic [3:0] s_dut0;
  state_e     st_w [5];

  assign s_w[0] = {4'h0, s_dut0};

  serial_adder_subtractor #(.WIDTH(4), .DIGIT(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sel(sel_v),
    .A(a_v[3:0]), .B(b_v[3:0]), .busy(busy_w[0]), .done(done_w[0]),
    .S(s_dut0), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]),
    .dbg_state_o(st_w[0]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sel(sel_v),
    .A(a_v), .B(b_v), .busy(busy_w[1]), .done(done_w[1]),
    .S(s_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]),
    .dbg_state_o(st_w[1]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sel(sel_v),
    .A(a_v), .B(b_v), .busy(busy_w[2]), .done(done_w[2]),
    .S(s_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]),
    .dbg_state_o(st_w[2]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sel(sel_v),
    .A(a_v), .B(b_v), .busy(busy_w[3]), .done(done_w[3]),
    .S(s_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3]), .zero(zero_w[3]),
    .dbg_state_o(st_w[3]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(8)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .sel(sel_v),
    .A(a_v), .B(b_v), .busy(busy_w[4]), .done(done_w[4]),
    .S(s_w[4]), .cout(cout_w[4]), .ovf(ovf_w[4]), .zero(zero_w[4]),
    .dbg_state_o(st_w[4]));

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] pk(input logic [7:0] s, input logic c, input logic v,
                                     input logic z);
    return {s, c, v, z};
  endfunction

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic logic [10:0] ref_model(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input logic s);
    logic [7:0] mask, am, bb, sum;
    logic [8:0] full;
    logic       c, v;
    mask = (w == 8) ? 8'hFF : 8'h0F;
    am   = a & mask;
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bb} + {8'b0, s};
    sum  = full[7:0] & mask;
    c    = (w == 8) ? full[8] : full[4];
    v    = (am[w-1] == bb[w-1]) && (sum[w-1] != am[w-1]);
    return pk(sum, c, v, sum == 8'h00);
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    logic [10:0] e_v;
    for (int d = 0; d < 5; d++) begin
      if (done_w[d]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done_dut%0d: got done=1 expected no pending result", d);
        end else begin
          e_v = exp_q.pop_front();
          check($sformatf("result_dut%0d", d),
                {21'b0, s_w[d], cout_w[d], ovf_w[d], zero_w[d]}, {21'b0, e_v});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [10:0] exp);
    int lat;
    int bc;
    @(posedge clk); #1;
    a_v = a; b_v = b; sel_v = s; start_v[d] = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    // Operand changes after acceptance must not disturb the result.
    a_v = 8'($urandom); b_v = 8'($urandom); sel_v = 1'($urandom);
    lat = 0;
    bc  = 0;
    while (!done_w[d] && lat < 40) begin
      if (busy_w[d]) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_dut%0d", d), lat, LAT[d]);
    check($sformatf("busy_cycles_dut%0d", d), bc, LAT[d]);
    check($sformatf("busy_low_in_done_dut%0d", d), busy_w[d], 1'b0);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_done, second_done, dcount, d;
    logic [7:0] ra, rb;
    logic       rs;

    vecs[0] = '{0, 8'h05, 8'h0A, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h05, 8'h0A, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 8'h0A, 8'h0A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{0, 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{2, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{3, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{4, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {busy_w, done_w, cout_w, ovf_w, zero_w}, 25'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("reset_S_dut%0d", i), s_w[i], 8'h00);
      check($sformatf("reset_state_dut%0d", i), st_w[i], IDLE);
    end
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].sel,
             pk(vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z));
    end

    // start held high: re-accepted only in the DONE cycle
    @(posedge clk); #1;
    a_v = 8'h03; b_v = 8'h04; sel_v = 1'b0; start_v[0] = 1'b1;
    exp_q.push_back(pk(8'h07, 1'b0, 1'b0, 1'b0));
    first_done  = -1;
    second_done = -1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        a_v = 8'h01; b_v = 8'h02;
        exp_q.push_back(pk(8'h03, 1'b0, 1'b0, 1'b0));
      end
      if (cyc == 5) begin
        check("b2b_busy_after_reaccept", busy_w[0], 1'b1);
        a_v = 8'h09; b_v = 8'h09;
      end
      if (done_w[0]) begin
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) begin
          second_done = cyc;
          start_v[0] = 1'b0;
        end
      end
    end
    start_v[0] = 1'b0;
    check("b2b_first_done_cycle", first_done, 4);
    check("b2b_done_spacing", second_done - first_done, 5);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    a_v = 8'h05; b_v = 8'h0A; sel_v = 1'b0; start_v[0] = 1'b1;
    exp_q.push_back(pk(8'h0F, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrun_reset_S", s_w[0], 8'h00);
    check("midrun_reset_flags", {busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0]}, 5'b0);
    check("midrun_reset_state", st_w[0], IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_w[0]) dcount++;
    end
    check("no_done_after_reset", dcount, 0);
    run_op(0, 8'h07, 8'h03, 1'b1, pk(8'h04, 1'b1, 1'b0, 1'b0));

    // Random sweep across the WIDTH=8 instances
    for (int i = 0; i < 997; i++) begin
      d  = 2 + int'($urandom_range(0, 2));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_op(d, ra, rb, rs, ref_model(8, ra, rb, rs));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
- Parametrised, digit-serial successor of the 4-bit combinational adder/subtractor.
- Processes DIGIT bits of A ± B per clock, LSB first, so one narrow adder serves a WIDTH-bit operation.
- Uses a start/busy/done handshake and reports carry, signed overflow and zero flags.
- Used in later lab datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; ≥ 2.
- DIGIT, 1, bits processed per cycle; WIDTH mod DIGIT must be 0 (elaboration-time check, fatal error otherwise).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; operands sampled on the same edge.
- sel  in  1  0 = A+B, 1 = A−B.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- S  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for subtraction 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  two's-complement overflow.
- zero  out  1  S == 0.

Behaviour:
- Definitions:
  - N = WIDTH/DIGIT.
  - States: IDLE, RUN, DONE.
  - Internal: operand shift registers a_sh, b_sh (b_sh holds B, or ~B when sel = 1), carry register c, digit counter cnt (0..N−1), result shift register r_sh.
- Reset (rst_n = 0, at any time including mid-RUN):
  - state = IDLE.
  - busy = 0, done = 0, S = 0, cout = 0, ovf = 0, zero = 0.
  - Internal registers cleared.
  - Any in-flight operation is discarded.
- IDLE:
  - start = 1 on an edge latches A, sel ? ~B : B, sets c = sel and cnt = 0, and moves to RUN.
  - start = 0: stay in IDLE.
- RUN (busy = 1):
  - Each edge adds the low DIGIT bits of a_sh and b_sh with carry c.
  - The sum digit shifts into the MSB end of r_sh; a_sh and b_sh shift right by DIGIT; c takes the digit carry-out; cnt increments.
  - On the edge where cnt == N−1:
    - S ← final r_sh value (including this digit).
    - cout ← digit carry-out.
    - ovf ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
    - zero ← (final S == 0).
    - state → DONE.
- DONE (busy = 0, done = 1 for exactly one cycle):
  - start = 1 accepts a new operation (back-to-back) and goes to RUN.
  - Otherwise return to IDLE.
- Latency: start sampled at edge k; done = 1 and outputs valid after edge k+N. With back-to-back starts, throughput is one result per N+1 cycles.
- S, cout, ovf and zero hold their last values until the next completion or reset. They are never updated mid-RUN.
- start while busy = 1 is ignored; no queueing.
- A, B and sel changes after the accepting edge have no effect on the running operation.
- N = 1 (DIGIT = WIDTH) is legal: RUN lasts one cycle.

Decomposition:
- Package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Helper function computing the counter width, clog2(N) with a minimum of 1.
- Sub-module digit_adder:
  - Combinational DIGIT-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into its top bit).
  - c_msb is used for ovf on the last digit.

Test Plan:
1. WIDTH=4, DIGIT=1: A=5, B=10, sel=0, 1-cycle start -> busy for 4 cycles; then done, S=15, cout=0, ovf=0, zero=0.
2. WIDTH=4, DIGIT=1 (each case run separately):
   - A=5, B=10, sel=1 -> S=11, cout=0, ovf=1.
   - A=10, B=10, sel=1 -> S=0, cout=1, ovf=0, zero=1.
   - A=10, B=5, sel=0 -> S=15, cout=0, ovf=0.
3. WIDTH=8, DIGIT=4:
   - A=0x7F, B=0x01, sel=0 -> done 2 cycles after start; S=0x80, ovf=1, cout=0.
   - Then A=0xFF, B=0x01, sel=0 -> S=0x00, cout=1, zero=1, ovf=0.
4. Start held high continuously (WIDTH=4, DIGIT=1):
   - Second request accepted only in the DONE cycle; done pulses every 5 cycles.
   - A/B changes during RUN do not alter the result.
5. Reset mid-operation:
   - Assert rst_n=0 asynchronously (between edges) during cycle 2 of RUN -> all outputs 0 immediately.
   - No done pulse follows.
   - Next start after reset release produces a correct result.
6. Randomised sweep at WIDTH=8, DIGIT ∈ {1, 2, 8}: 1000 operations compared against a reference model of A ± B (S, cout, ovf, zero). Includes 0x80 − 0x01 -> S=0x7F, ovf=1, cout=1.
